image_frame_sequencer: RTL and testbench
========================================

Name: image_frame_sequencer

Overview:
- Controls the 256-pixel image buffer between the AXI4-Lite write port and the SNN core.
- Tracks which pixel indices have been written. Once all are present, it locks out further writes, sequences every pixel to the core through a valid/ready stream, then waits for the core to finish before reopening the buffer.
- Sits between the AXI input block, the image buffer read port and the SNN core.

Parameters:
- N_PIXELS, 256, number of pixels per frame (power of two, at most 2^ADDR_W).
- PIXEL_W, 8, pixel width in bits.
- ADDR_W, 8, pixel index width.
- FRAME_CNT_W, 16, completed-frame counter width.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- wr_done_i  in  1  one-cycle pulse per accepted AXI pixel write.
- wr_addr_i  in  ADDR_W  pixel index of that write; valid with wr_done_i.
- wr_ready_o  out  1  buffer open for writes (high only in COLLECT).
- buf_rd_addr_o  out  ADDR_W  image buffer read address.
- buf_rd_data_i  in  PIXEL_W  buffer read data; valid one cycle after address.
- img_start_o  out  1  one-cycle pulse: frame complete, streaming begins.
- pix_valid_o  out  1  stream valid.
- pix_ready_i  in  1  stream ready from SNN core.
- pix_data_o  out  PIXEL_W  pixel value.
- pix_idx_o  out  ADDR_W  pixel index of pix_data_o.
- pix_last_o  out  1  high with pixel N_PIXELS-1.
- img_done_i  in  1  core pulse: inference on current frame finished.
- abort_i  in  1  synchronous soft clear.
- busy_o  out  1  state is not COLLECT.
- overrun_o  out  1  sticky: a write arrived while wr_ready_o was low.
- frame_cnt_o  out  FRAME_CNT_W  frames completed (wraps).

Behaviour:

Reset:
- State COLLECT, written mask all 0, written count 0, idx 0.
- wr_ready_o=1. All other outputs 0.

State machine: COLLECT, FETCH, CAPTURE, PRESENT, WAIT_CORE.

COLLECT:
- On wr_done_i with wr_addr_i < N_PIXELS: set mask[wr_addr_i].
- Count increments only if that mask bit was previously 0. Duplicate writes are allowed and do not count.
- Addresses >= N_PIXELS are ignored and do not set overrun.
- When a write makes count == N_PIXELS, the next cycle enters FETCH with idx=0 and img_start_o=1 for exactly that cycle.

FETCH:
- buf_rd_addr_o=idx. Next state CAPTURE.

CAPTURE:
- Register buf_rd_data_i into pix_data_o, idx into pix_idx_o.
- pix_last_o=(idx==N_PIXELS-1).
- Next state PRESENT with pix_valid_o=1.

PRESENT:
- Hold pix_valid_o, pix_data_o, pix_idx_o and pix_last_o stable until pix_ready_i is sampled high.
- On handshake with pix_last_o=0: pix_valid_o drops, idx+1, go to FETCH.
- On handshake with pix_last_o=1: go to WAIT_CORE.
- Minimum 3 cycles per pixel.

WAIT_CORE:
- On img_done_i: clear mask and count, idx=0, frame_cnt_o+1 (wraps modulo 2^FRAME_CNT_W), return to COLLECT.
- img_done_i outside WAIT_CORE is ignored.

Output decodes:
- wr_ready_o=(state==COLLECT).
- busy_o=!wr_ready_o.

overrun_o:
- Set when wr_done_i occurs in any state other than COLLECT. That write is discarded and does not touch the mask.
- Cleared only by reset or abort_i.

abort_i (any state):
- Next cycle enters COLLECT with mask, count and idx cleared, pix_valid_o=0, img_start_o=0 and overrun_o cleared.
- frame_cnt_o is unchanged.
- abort_i takes priority over every simultaneous event (wr_done_i, handshake, img_done_i).

Simultaneous events:
- wr_done_i in the same cycle as the COLLECT→FETCH transition is not possible, because the transition is registered.
- wr_done_i in the first FETCH cycle sets overrun_o.

Asynchronous reset mid-stream drops pix_valid_o immediately. No partial frame state survives.

Test Plan:
- Write indices 0..255 once each, pix_ready_i tied high → img_start_o pulses one cycle after the 256th wr_done_i. Pixels stream with pix_idx_o 0..255, one per 3 cycles, pix_last_o only on idx 255. pix_data_o equals the buffer contents.
- Write index 5 three times, then all others → count reaches 256 only after the 256th distinct index. The stream starts exactly once.
- During PRESENT, hold pix_ready_i low for 10 cycles → pix_valid_o, pix_data_o and pix_idx_o stay stable. Advance occurs only on the cycle pix_ready_i is sampled high.
- Pulse wr_done_i during PRESENT → overrun_o goes high and stays high. The mask is unaffected. After img_done_i, the next frame collects normally, overrun_o remains 1, and frame_cnt_o=1.
- abort_i asserted at pixel 100 together with pix_ready_i → next cycle state COLLECT, pix_valid_o=0, wr_ready_o=1, frame_cnt_o unchanged, overrun_o cleared. A fresh 256 writes restart streaming at idx 0.
- Assert ARESETN low mid-WAIT_CORE, then pulse img_done_i after release → all outputs at reset values. img_done_i is ignored and frame_cnt_o=0.

Source files
------------

// File: rtl/image_frame_sequencer.sv
// Frame sequencer for the image buffer: collects a full frame of pixel writes,
// streams every pixel to the SNN core, then waits for inference to finish.
module image_frame_sequencer #(
   parameter int N_PIXELS    = 256,
   parameter int PIXEL_W     = 8,
   parameter int ADDR_W      = 8,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   wr_done_i,
   input  logic [ADDR_W-1:0]      wr_addr_i,
   output logic                   wr_ready_o,
   output logic [ADDR_W-1:0]      buf_rd_addr_o,
   input  logic [PIXEL_W-1:0]     buf_rd_data_i,
   output logic                   img_start_o,
   output logic                   pix_valid_o,
   input  logic                   pix_ready_i,
   output logic [PIXEL_W-1:0]     pix_data_o,
   output logic [ADDR_W-1:0]      pix_idx_o,
   output logic                   pix_last_o,
   input  logic                   img_done_i,
   input  logic                   abort_i,
   output logic                   busy_o,
   output logic                   overrun_o,
   output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

   typedef enum logic [2:0] {
      COLLECT   = 3'd0,
      FETCH     = 3'd1,
      CAPTURE   = 3'd2,
      PRESENT   = 3'd3,
      WAIT_CORE = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]      N_FULL    = (ADDR_W+1)'(N_PIXELS);
   localparam logic [ADDR_W:0]      N_ALMOST  = (ADDR_W+1)'(N_PIXELS - 1);
   localparam logic [ADDR_W:0]      CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0]    IDX_LAST  = ADDR_W'(N_PIXELS - 1);
   localparam logic [ADDR_W-1:0]    IDX_ONE   = ADDR_W'(1);
   localparam logic [FRAME_CNT_W-1:0] FRM_ONE = FRAME_CNT_W'(1);

   state_t                  state_r, state_s;
   logic [N_PIXELS-1:0]     mask_r;
   logic [ADDR_W:0]         count_r;
   logic [ADDR_W-1:0]       idx_r;
   logic                    img_start_r;
   logic                    pix_valid_r;
   logic [PIXEL_W-1:0]      pix_data_r;
   logic [ADDR_W-1:0]       pix_idx_r;
   logic                    pix_last_r;
   logic                    overrun_r;
   logic [FRAME_CNT_W-1:0]  frame_cnt_r;
   logic                    new_bit_s;
   logic                    handshake_s;
   logic                    core_done_s;

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r <= COLLECT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; abort overrides every other event
   always_comb begin
      state_s     = state_r;
      new_bit_s   = 1'b0;
      handshake_s = 1'b0;
      core_done_s = 1'b0;
      if (abort_i) begin
         state_s = COLLECT;
      end else begin
         case (state_r)
            COLLECT: begin
               if (wr_done_i && ({1'b0, wr_addr_i} < N_FULL)) begin
                  new_bit_s = ~mask_r[wr_addr_i];
                  if (new_bit_s && (count_r == N_ALMOST)) begin
                     state_s = FETCH;
                  end else begin
                     state_s = COLLECT;
                  end
               end else begin
                  state_s = COLLECT;
               end
            end
            FETCH:   state_s = CAPTURE;
            CAPTURE: state_s = PRESENT;
            PRESENT: begin
               if (pix_ready_i) begin
                  handshake_s = 1'b1;
                  state_s     = pix_last_r ? WAIT_CORE : FETCH;
               end else begin
                  state_s = PRESENT;
               end
            end
            WAIT_CORE: begin
               if (img_done_i) begin
                  core_done_s = 1'b1;
                  state_s     = COLLECT;
               end else begin
                  state_s = WAIT_CORE;
               end
            end
            default: state_s = COLLECT;
         endcase
      end
   end

   // Frame bookkeeping and registered stream outputs
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         mask_r      <= '0;
         count_r     <= '0;
         idx_r       <= '0;
         img_start_r <= 1'b0;
         pix_valid_r <= 1'b0;
         pix_data_r  <= '0;
         pix_idx_r   <= '0;
         pix_last_r  <= 1'b0;
         overrun_r   <= 1'b0;
         frame_cnt_r <= '0;
      end else if (abort_i) begin
         mask_r      <= '0;
         count_r     <= '0;
         idx_r       <= '0;
         img_start_r <= 1'b0;
         pix_valid_r <= 1'b0;
         pix_last_r  <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         img_start_r <= (state_r == COLLECT) && (state_s == FETCH);
         overrun_r   <= overrun_r | (wr_done_i && (state_r != COLLECT));
         case (state_r)
            COLLECT: begin
               if (new_bit_s) begin
                  mask_r[wr_addr_i] <= 1'b1;
                  count_r           <= count_r + CNT_ONE;
               end
            end
            CAPTURE: begin
               pix_data_r  <= buf_rd_data_i;
               pix_idx_r   <= idx_r;
               pix_last_r  <= (idx_r == IDX_LAST);
               pix_valid_r <= 1'b1;
            end
            PRESENT: begin
               if (handshake_s) begin
                  pix_valid_r <= 1'b0;
                  pix_last_r  <= 1'b0;
                  if (!pix_last_r) begin
                     idx_r <= idx_r + IDX_ONE;
                  end
               end
            end
            WAIT_CORE: begin
               if (core_done_s) begin
                  mask_r      <= '0;
                  count_r     <= '0;
                  idx_r       <= '0;
                  frame_cnt_r <= frame_cnt_r + FRM_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign wr_ready_o    = (state_r == COLLECT);
   assign busy_o        = (state_r != COLLECT);
   assign buf_rd_addr_o = idx_r;
   assign img_start_o   = img_start_r;
   assign pix_valid_o   = pix_valid_r;
   assign pix_data_o    = pix_data_r;
   assign pix_idx_o     = pix_idx_r;
   assign pix_last_o    = pix_last_r;
   assign overrun_o     = overrun_r;
   assign frame_cnt_o   = frame_cnt_r;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Directed bench for image_frame_sequencer: a behavioural image buffer plus a
// queue of expected pixels checked at every stream handshake.
module tb_image_frame_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        wr_done_i;
   logic [7:0]  wr_addr_i;
   logic        wr_ready_o;
   logic [7:0]  buf_rd_addr_o;
   logic [7:0]  buf_rd_data_i;
   logic        img_start_o;
   logic        pix_valid_o;
   logic        pix_ready_i;
   logic [7:0]  pix_data_o;
   logic [7:0]  pix_idx_o;
   logic        pix_last_o;
   logic        img_done_i;
   logic        abort_i;
   logic        busy_o;
   logic        overrun_o;
   logic [15:0] frame_cnt_o;

   typedef struct packed {
      logic [7:0] idx;
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [7:0] mem [256];
   int         errors = 0;
   int         checks = 0;
   int         starts = 0;
   int         cyc = 0;
   int         last_hs = 0;
   bit         rate_chk = 1'b0;

   image_frame_sequencer dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .wr_done_i(wr_done_i), .wr_addr_i(wr_addr_i), .wr_ready_o(wr_ready_o),
      .buf_rd_addr_o(buf_rd_addr_o), .buf_rd_data_i(buf_rd_data_i),
      .img_start_o(img_start_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
      .pix_data_o(pix_data_o), .pix_idx_o(pix_idx_o), .pix_last_o(pix_last_o),
      .img_done_i(img_done_i), .abort_i(abort_i), .busy_o(busy_o),
      .overrun_o(overrun_o), .frame_cnt_o(frame_cnt_o)
   );

   always #5 ACLK = ~ACLK;

   // Synchronous-read image buffer: data one cycle after address
   always @(posedge ACLK) begin
      buf_rd_data_i <= mem[buf_rd_addr_o];
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pdat(input int a, input int f);
      return 8'((a * 13 + f * 41 + 7) & 255);
   endfunction

   // Handshake monitor: pops and compares one expected pixel per transfer
   always @(negedge ACLK) begin
      #1;
      if (img_start_o) starts++;
      if (ARESETN && pix_valid_o && pix_ready_i && !abort_i) begin
         check("hs_queue_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            check("pix_idx", 32'(pix_idx_o), 32'(mon_e.idx));
            check("pix_data", 32'(pix_data_o), 32'(mon_e.data));
            check("pix_last", 32'(pix_last_o), 32'(mon_e.last));
            if (rate_chk && mon_e.idx != 8'd0) check("pix_rate", 32'(cyc - last_hs), 32'd3);
            last_hs = cyc;
         end
      end
   end

   task automatic wr(input int a, input logic [7:0] d, input bit upd);
      wr_done_i = 1'b1;
      wr_addr_i = a[7:0];
      if (upd) mem[a] = d;
      @(negedge ACLK);
      wr_done_i = 1'b0;
   endtask

   task automatic push_frame();
      for (int i = 0; i < 256; i++) begin
         q.push_back({i[7:0], mem[i], (i == 255)});
      end
   endtask

   task automatic fill(input int f, input bit rev);
      int a;
      for (int i = 0; i < 256; i++) begin
         a = rev ? 255 - i : i;
         wr(a, pdat(a, f), 1'b1);
      end
      check("start_pulse", 32'(img_start_o), 32'd1);
      check("busy_at_start", 32'(busy_o), 32'd1);
      push_frame();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         @(negedge ACLK);
         n++;
      end
      check("stream_drained", 32'(q.size()), 32'd0);
      @(negedge ACLK);
      check("wait_core_busy", 32'(busy_o), 32'd1);
      check("wait_core_novalid", 32'(pix_valid_o), 32'd0);
   endtask

   task automatic core_done();
      img_done_i = 1'b1;
      @(negedge ACLK);
      img_done_i = 1'b0;
      check("reopen_wr_ready", 32'(wr_ready_o), 32'd1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ARESETN = 1'b0; wr_done_i = 1'b0; wr_addr_i = 8'h00; pix_ready_i = 1'b1;
      img_done_i = 1'b0; abort_i = 1'b0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      check("rst_wr_ready", 32'(wr_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(pix_valid_o), 32'd0);
      check("rst_start", 32'(img_start_o), 32'd0);
      check("rst_overrun", 32'(overrun_o), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);

      // Frame 1: in-order writes, ready tied high
      rate_chk = 1'b1;
      fill(1, 1'b0);
      @(negedge ACLK);
      check("start_one_cycle", 32'(img_start_o), 32'd0);
      drain();
      core_done();
      check("frame_cnt_1", 32'(frame_cnt_o), 32'd1);

      // Frame 2: duplicates, stray img_done, stall and overrun
      rate_chk = 1'b0;
      img_done_i = 1'b1;
      @(negedge ACLK);
      img_done_i = 1'b0;
      check("img_done_ignored", 32'(frame_cnt_o), 32'd1);
      pix_ready_i = 1'b0;
      wr(5, 8'h11, 1'b1);
      wr(5, 8'h22, 1'b1);
      wr(5, pdat(5, 2), 1'b1);
      for (int i = 0; i < 256; i++) begin
         if (i != 5) begin
            if (i == 255) begin
               check("dup_not_counted_ready", 32'(wr_ready_o), 32'd1);
               check("dup_no_start", 32'(starts), 32'd1);
            end
            wr(i, pdat(i, 2), 1'b1);
         end
      end
      check("start_pulse_f2", 32'(img_start_o), 32'd1);
      push_frame();
      n = 0;
      while (!pix_valid_o && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      check("first_valid", 32'(pix_valid_o), 32'd1);
      for (int k = 0; k < 10; k++) begin
         check("stall_valid", 32'(pix_valid_o), 32'd1);
         check("stall_idx", 32'(pix_idx_o), 32'(q[0].idx));
         check("stall_data", 32'(pix_data_o), 32'(q[0].data));
         if (k == 4) wr(7, 8'hEE, 1'b0);
         else @(negedge ACLK);
      end
      check("overrun_set", 32'(overrun_o), 32'd1);
      pix_ready_i = 1'b1;
      drain();
      check("overrun_sticky", 32'(overrun_o), 32'd1);
      core_done();
      check("frame_cnt_2", 32'(frame_cnt_o), 32'd2);
      check("starts_once", 32'(starts), 32'd2);

      // Frame 3: abort at pixel 100 with ready high
      rate_chk = 1'b1;
      fill(3, 1'b0);
      check("overrun_still_set", 32'(overrun_o), 32'd1);
      n = 0;
      while (!(pix_valid_o && pix_idx_o == 8'd100) && n < 1000) begin
         @(negedge ACLK);
         n++;
      end
      check("reach_pixel_100", 32'(pix_idx_o), 32'd100);
      abort_i = 1'b1;
      @(negedge ACLK);
      abort_i = 1'b0;
      q.delete();
      check("abort_wr_ready", 32'(wr_ready_o), 32'd1);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_valid", 32'(pix_valid_o), 32'd0);
      check("abort_overrun", 32'(overrun_o), 32'd0);
      check("abort_frame_cnt", 32'(frame_cnt_o), 32'd2);
      check("abort_rd_addr", 32'(buf_rd_addr_o), 32'd0);
      fill(4, 1'b1);
      drain();
      core_done();
      check("frame_cnt_3", 32'(frame_cnt_o), 32'd3);

      // Frame 5: async reset while waiting for the core
      fill(5, 1'b0);
      drain();
      ARESETN = 1'b0;
      #1;
      check("arst_wr_ready", 32'(wr_ready_o), 32'd1);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      check("arst_valid", 32'(pix_valid_o), 32'd0);
      check("arst_last", 32'(pix_last_o), 32'd0);
      check("arst_rd_addr", 32'(buf_rd_addr_o), 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      img_done_i = 1'b1;
      @(negedge ACLK);
      img_done_i = 1'b0;
      @(negedge ACLK);
      check("post_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      check("post_rst_wr_ready", 32'(wr_ready_o), 32'd1);
      check("post_rst_overrun", 32'(overrun_o), 32'd0);
      check("total_starts", 32'(starts), 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
